// File: rtl/easyaxi_rd_arbiter.sv
// N-master to 1-slave AXI read interconnect: round-robin AR arbitration with the
// master index prepended to ARID, R beats routed back by that index, per-master outstanding limit.
module easyaxi_rd_arbiter #(
    parameter int NUM_MST  = 4,
    parameter int MAX_OUTS = 4,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int USER_W   = 1,
    parameter int IDX_W    = $clog2(NUM_MST)
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [NUM_MST-1:0]        mst_arvalid,
    output logic [NUM_MST-1:0]        mst_arready,
    input  logic [NUM_MST*ID_W-1:0]   mst_arid,
    input  logic [NUM_MST*ADDR_W-1:0] mst_araddr,
    input  logic [NUM_MST*8-1:0]      mst_arlen,
    input  logic [NUM_MST*3-1:0]      mst_arsize,
    input  logic [NUM_MST*2-1:0]      mst_arburst,
    input  logic [NUM_MST*USER_W-1:0] mst_aruser,

    output logic [NUM_MST-1:0]        mst_rvalid,
    input  logic [NUM_MST-1:0]        mst_rready,
    output logic [ID_W-1:0]           mst_rid,
    output logic [DATA_W-1:0]         mst_rdata,
    output logic [1:0]                mst_rresp,
    output logic                      mst_rlast,
    output logic [USER_W-1:0]         mst_ruser,

    output logic                      slv_arvalid,
    input  logic                      slv_arready,
    output logic [ID_W+IDX_W-1:0]     slv_arid,
    output logic [ADDR_W-1:0]         slv_araddr,
    output logic [7:0]                slv_arlen,
    output logic [2:0]                slv_arsize,
    output logic [1:0]                slv_arburst,
    output logic [USER_W-1:0]         slv_aruser,

    input  logic                      slv_rvalid,
    output logic                      slv_rready,
    input  logic [ID_W+IDX_W-1:0]     slv_rid,
    input  logic [DATA_W-1:0]         slv_rdata,
    input  logic [1:0]                slv_rresp,
    input  logic                      slv_rlast,
    input  logic [USER_W-1:0]         slv_ruser,

    output logic                      err_decode
);

    localparam int CNT_W = $clog2(MAX_OUTS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_pick;
    logic             w_found;
    logic [CNT_W-1:0] r_out_cnt [NUM_MST];
    logic             r_err_decode;

    logic [NUM_MST-1:0] w_elig;
    logic [NUM_MST-1:0] w_ar_inc;
    logic [NUM_MST-1:0] w_r_dec;
    logic               w_ar_hs;
    logic               w_gvalid;
    logic [ID_W-1:0]    w_gid;
    logic [IDX_W-1:0]   w_ridx;
    logic               w_ridx_ok;
    logic               w_rsel_ready;
    logic               w_r_hs;

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            w_elig[i] = mst_arvalid[i] && (r_out_cnt[i] < CNT_W'(MAX_OUTS));
        end
    end

    // Rotating priority: first pass covers rr_ptr..NUM_MST-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (!w_found && w_elig[i] && (i >= int'(r_rr_ptr))) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_MST; i++) begin
            if (!w_found && w_elig[i]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_gvalid    = 1'b0;
        w_gid       = '0;
        slv_araddr  = '0;
        slv_arlen   = '0;
        slv_arsize  = '0;
        slv_arburst = '0;
        slv_aruser  = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_gvalid    = mst_arvalid[i];
                w_gid       = mst_arid[i*ID_W +: ID_W];
                slv_araddr  = mst_araddr[i*ADDR_W +: ADDR_W];
                slv_arlen   = mst_arlen[i*8 +: 8];
                slv_arsize  = mst_arsize[i*3 +: 3];
                slv_arburst = mst_arburst[i*2 +: 2];
                slv_aruser  = mst_aruser[i*USER_W +: USER_W];
            end
        end
    end

    assign slv_arid = {r_grant, w_gid};

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        slv_arvalid = 1'b0;
        mst_arready = '0;
        w_ar_hs     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                slv_arvalid = w_gvalid;
                for (int i = 0; i < NUM_MST; i++) begin
                    if (r_grant == IDX_W'(i)) begin
                        mst_arready[i] = slv_arready;
                    end
                end
                w_ar_hs = w_gvalid && slv_arready;
                if (w_ar_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // R path is purely combinational and independent of the AR state machine.
    assign w_ridx    = slv_rid[ID_W+IDX_W-1:ID_W];
    assign w_ridx_ok = int'(w_ridx) < NUM_MST;

    always_comb begin
        mst_rvalid   = '0;
        w_rsel_ready = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (w_ridx == IDX_W'(i)) begin
                mst_rvalid[i] = slv_rvalid;
                w_rsel_ready  = mst_rready[i];
            end
        end
    end

    assign slv_rready = w_ridx_ok ? w_rsel_ready : 1'b1;
    assign w_r_hs     = slv_rvalid && slv_rready;
    assign mst_rid    = slv_rid[ID_W-1:0];
    assign mst_rdata  = slv_rdata;
    assign mst_rresp  = slv_rresp;
    assign mst_rlast  = slv_rlast;
    assign mst_ruser  = slv_ruser;
    assign err_decode = r_err_decode;

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            w_ar_inc[i] = w_ar_hs && (r_grant == IDX_W'(i));
            w_r_dec[i]  = w_r_hs && slv_rlast && w_ridx_ok && (w_ridx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_err_decode <= 1'b0;
            for (int i = 0; i < NUM_MST; i++) begin
                r_out_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_ar_hs) begin
                r_rr_ptr <= (r_grant == IDX_W'(NUM_MST - 1)) ? '0 : r_grant + 1'b1;
            end
            if (w_r_hs && !w_ridx_ok) begin
                r_err_decode <= 1'b1;
            end
            // Simultaneous issue and completion leave the count unchanged; no wrap below zero.
            for (int i = 0; i < NUM_MST; i++) begin
                if (w_ar_inc[i] && !w_r_dec[i]) begin
                    r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
                end else if (!w_ar_inc[i] && w_r_dec[i] && (r_out_cnt[i] != '0)) begin
                    r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule
